// File: rtl/genius_pkg.sv
// Shared types and constants for the memory-game core: FSM states, default
// sequence length and active-low seven-segment patterns ordered {g,f,e,d,c,b,a}.
package genius_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAdd,
    StShowOn,
    StShowOff,
    StInput,
    StWin,
    StLose
  } state_e;

  localparam int unsigned MaxLenDefault = 16;

  localparam logic [7:0] SeedFallback = 8'hA5;

  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegE     = 7'b0000110;
  localparam logic [6:0] SegP     = 7'b0001100;

  function automatic logic [6:0] seg_digit(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SegBlank;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Single-digit decimal to active-low seven-segment pattern, with forced blank.
module seg7_decoder
  import genius_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SegBlank : seg_digit(digit_i);

endmodule

// File: rtl/genius_game.sv
// Memory game core: shows a growing LFSR-derived colour sequence on LEDs and
// checks the player's button presses against it, level shown in decimal.
module genius_game
  import genius_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES    = 8,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_LEN        = MaxLenDefault
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] btn,
  input  logic [9:2] sw,
  output logic [6:0] segd0,
  output logic [6:0] segd1,
  output logic [6:0] segd2,
  output logic [6:0] segd3,
  output logic [9:0] leds
);

  localparam int unsigned ShowGap = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned CntMax  = (ShowGap > TIMEOUT_CYCLES) ? ShowGap : TIMEOUT_CYCLES;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam int unsigned IdxW    = $clog2(MAX_LEN);

  state_e          state_q, state_d;
  logic            start_q, start_prev_q;
  logic [2:0]      btn_q, btn_prev_q;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [6:0]      level_q, level_d;
  logic [6:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            refill_q, refill_d;
  logic [1:0]      seq_q [MAX_LEN];
  logic            seq_we;

  logic       start_edge;
  logic [2:0] btn_edge;
  logic [7:0] lfsr_step;
  logic [1:0] new_colour;
  logic [1:0] cur_colour;
  logic [2:0] cur_onehot;
  logic       last_entry;

  assign start_edge = start_q & ~start_prev_q;
  assign btn_edge   = btn_q & ~btn_prev_q;
  assign lfsr_step  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign new_colour = (lfsr_step[1:0] == 2'd3) ? 2'd0 : lfsr_step[1:0];
  assign cur_colour = seq_q[idx_q[IdxW-1:0]];
  assign cur_onehot = 3'b001 << cur_colour;
  assign last_entry = (idx_q == level_q - 7'd1);

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    level_d  = level_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    refill_d = refill_q;
    seq_we   = 1'b0;
    if (start_edge) begin
      state_d  = StAdd;
      lfsr_d   = (sw == 8'd0) ? SeedFallback : sw;
      level_d  = '0;
      idx_d    = '0;
      cnt_d    = '0;
      refill_d = 1'b0;
    end else begin
      unique case (state_q)
        StAdd: begin
          seq_we  = 1'b1;
          lfsr_d  = lfsr_step;
          level_d = level_q + 7'd1;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = StShowOn;
        end
        StShowOn: begin
          if (cnt_q == CntW'(SHOW_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = StShowOff;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StShowOff: begin
          if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
            cnt_d = '0;
            // A gap following a completed round leads to the next colour being added.
            if (refill_q) begin
              refill_d = 1'b0;
              state_d  = StAdd;
            end else if (last_entry) begin
              idx_d   = '0;
              state_d = StInput;
            end else begin
              idx_d   = idx_q + 7'd1;
              state_d = StShowOn;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StInput: begin
          if (btn_edge != 3'b000) begin
            if (btn_edge == cur_onehot) begin
              cnt_d = '0;
              idx_d = idx_q + 7'd1;
              if (last_entry) begin
                if (level_q == 7'(MAX_LEN)) begin
                  state_d = StWin;
                end else begin
                  refill_d = 1'b1;
                  state_d  = StShowOff;
                end
              end
            end else begin
              state_d = StLose;
            end
          end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            state_d = StLose;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      btn_q        <= 3'b000;
      btn_prev_q   <= 3'b000;
      lfsr_q       <= SeedFallback;
      level_q      <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      refill_q     <= 1'b0;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        seq_q[i] <= 2'd0;
      end
    end else begin
      state_q      <= state_d;
      start_q      <= start;
      start_prev_q <= start_q;
      btn_q        <= btn;
      btn_prev_q   <= btn_q;
      lfsr_q       <= lfsr_d;
      level_q      <= level_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      refill_q     <= refill_d;
      if (seq_we) begin
        seq_q[level_q[IdxW-1:0]] <= new_colour;
      end
    end
  end

  always_comb begin
    leds    = '0;
    leds[7] = (state_q == StInput);
    leds[8] = (state_q == StWin);
    leds[9] = (state_q == StLose);
    if (state_q == StShowOn) begin
      leds[2:0] = cur_onehot;
    end else if (state_q == StInput) begin
      leds[2:0] = btn_q;
    end
  end

  always_comb begin
    unique case (state_q)
      StIdle:  segd3 = SegBlank;
      StWin:   segd3 = seg_digit(4'd0);
      StLose:  segd3 = SegE;
      default: segd3 = SegP;
    endcase
  end

  logic [3:0] tens, units;
  logic       idle;

  assign tens  = 4'(level_q / 7'd10);
  assign units = 4'(level_q % 7'd10);
  assign idle  = (state_q == StIdle);
  assign segd2 = SegBlank;

  seg7_decoder u_units (
    .digit_i(units),
    .blank_i(idle),
    .seg_o  (segd0)
  );

  seg7_decoder u_tens (
    .digit_i(tens),
    .blank_i(idle || (level_q < 7'd10)),
    .seg_o  (segd1)
  );

endmodule

// File: tb/tb_genius_game.sv
// Directed bench for genius_game: a default-size instance and a MAX_LEN=2 instance
// share the stimulus; each task drives one scenario and checks outputs at negedges.
module tb_genius_game;

  localparam logic [6:0] SegBl = 7'h7F;
  localparam logic [6:0] Seg0  = 7'b1000000;
  localparam logic [6:0] Seg1  = 7'b1111001;
  localparam logic [6:0] Seg2  = 7'b0100100;
  localparam logic [6:0] SegE  = 7'b0000110;
  localparam logic [6:0] SegP  = 7'b0001100;

  logic       clock;
  logic       reset;
  logic       start;
  logic [2:0] btn;
  logic [7:0] sw;

  logic [6:0] segd0_m, segd1_m, segd2_m, segd3_m;
  logic [9:0] leds_m;
  logic [6:0] segd0_w, segd1_w, segd2_w, segd3_w;
  logic [9:0] leds_w;

  int total = 0;
  int bad   = 0;

  logic [2:0] seen_col [$];
  int         seen_len [$];
  int         seen_gap [$];
  int         cap_tail;
  bit         cap_ok;

  genius_game u_main (
    .clock(clock),
    .reset(reset),
    .start(start),
    .btn  (btn),
    .sw   (sw),
    .segd0(segd0_m),
    .segd1(segd1_m),
    .segd2(segd2_m),
    .segd3(segd3_m),
    .leds (leds_m)
  );

  genius_game #(
    .MAX_LEN(2)
  ) u_win (
    .clock(clock),
    .reset(reset),
    .start(start),
    .btn  (btn),
    .sw   (sw),
    .segd0(segd0_w),
    .segd1(segd1_w),
    .segd2(segd2_w),
    .segd3(segd3_w),
    .leds (leds_w)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge where the DUT is in ADD.
  task automatic do_start(input logic [7:0] seed);
    sw    = seed;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
  endtask

  task automatic press(input logic [2:0] val);
    btn = val;
    @(negedge clock);
    btn = 3'b000;
    @(negedge clock);
  endtask

  // Records lit colours, lit run lengths and inter-colour gaps until INPUT appears.
  task automatic capture_show(input bit win_dut, input int budget);
    logic [9:0] l;
    int run;
    int gap;
    seen_col.delete();
    seen_len.delete();
    seen_gap.delete();
    run    = 0;
    gap    = 0;
    cap_ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      l = win_dut ? leds_w : leds_m;
      if (l[7]) begin
        cap_ok = 1'b1;
        if (run != 0) seen_len.push_back(run);
        break;
      end
      if (l[2:0] != 3'b000) begin
        if (run == 0) begin
          seen_col.push_back(l[2:0]);
          if (seen_col.size() > 1) seen_gap.push_back(gap);
        end
        run++;
        gap = 0;
      end else begin
        if (run != 0) begin
          seen_len.push_back(run);
          run = 0;
        end
        gap++;
      end
    end
    cap_tail = gap;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    btn   = 3'b000;
    sw    = 8'h00;
    #2;
    total++;
    if (leds_m !== 10'd0) begin
      bad++;
      $display("FAIL reset_leds got=%h exp=%h", leds_m, 10'd0);
    end
    total++;
    if ({segd3_m, segd2_m, segd1_m, segd0_m} !== {4{SegBl}}) begin
      bad++;
      $display("FAIL reset_segs got=%h exp=%h", {segd3_m, segd2_m, segd1_m, segd0_m}, {4{SegBl}});
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    total++;
    if (leds_m !== 10'd0 || segd3_m !== SegBl) begin
      bad++;
      $display("FAIL idle_after_reset got=%h/%h exp=%h/%h", leds_m, segd3_m, 10'd0, SegBl);
    end
  endtask

  task automatic test_first_round();
    do_start(8'h00);
    total++;
    if (segd3_m !== SegP || leds_m !== 10'd0 || segd0_m !== Seg0) begin
      bad++;
      $display("FAIL add_state got=%h/%h/%h exp=%h/%h/%h", segd3_m, leds_m, segd0_m, SegP, 10'd0, Seg0);
    end
    capture_show(1'b0, 100);
    total++;
    if (!cap_ok) begin
      bad++;
      $display("FAIL round1_reach_input got=%0d exp=1", cap_ok);
    end
    total++;
    if (seen_col.size() != 1 || seen_col[0] !== 3'b100) begin
      bad++;
      $display("FAIL round1_colour got=n%0d,%b exp=n1,100", seen_col.size(), seen_col[0]);
    end
    total++;
    if (seen_len.size() != 1 || seen_len[0] != 8 || cap_tail != 4) begin
      bad++;
      $display("FAIL round1_timing got=lit%0d,gap%0d exp=lit8,gap4", seen_len[0], cap_tail);
    end
    total++;
    if (leds_m !== 10'h080 || segd0_m !== Seg1 || segd1_m !== SegBl || segd2_m !== SegBl
        || segd3_m !== SegP) begin
      bad++;
      $display("FAIL round1_input got=%h %h%h%h%h exp=080 %h%h%h%h", leds_m, segd3_m, segd2_m,
               segd1_m, segd0_m, SegP, SegBl, SegBl, Seg1);
    end
  endtask

  task automatic test_second_round();
    btn = 3'b100;
    @(negedge clock);
    total++;
    if (leds_m !== 10'h084) begin
      bad++;
      $display("FAIL input_echo got=%h exp=%h", leds_m, 10'h084);
    end
    btn = 3'b000;
    @(negedge clock);
    total++;
    if (leds_m !== 10'd0 || segd3_m !== SegP) begin
      bad++;
      $display("FAIL refill_gap got=%h/%h exp=%h/%h", leds_m, segd3_m, 10'd0, SegP);
    end
    capture_show(1'b0, 100);
    total++;
    if (!cap_ok || seen_col.size() != 2 || seen_col[0] !== 3'b100 || seen_col[1] !== 3'b010) begin
      bad++;
      $display("FAIL round2_colours got=ok%0d n%0d %b,%b exp=ok1 n2 100,010", cap_ok,
               seen_col.size(), seen_col[0], seen_col[1]);
    end
    total++;
    if (seen_len.size() != 2 || seen_len[0] != 8 || seen_len[1] != 8 || seen_gap.size() != 1
        || seen_gap[0] != 4 || cap_tail != 4) begin
      bad++;
      $display("FAIL round2_timing got=lit%0d,%0d gap%0d tail%0d exp=lit8,8 gap4 tail4",
               seen_len[0], seen_len[1], seen_gap[0], cap_tail);
    end
    total++;
    if (segd0_m !== Seg2) begin
      bad++;
      $display("FAIL round2_level got=%h exp=%h", segd0_m, Seg2);
    end
  endtask

  task automatic test_wrong_button();
    press(3'b001);
    total++;
    if (leds_m !== 10'h200 || segd3_m !== SegE || segd0_m !== Seg2) begin
      bad++;
      $display("FAIL wrong_lose got=%h/%h/%h exp=%h/%h/%h", leds_m, segd3_m, segd0_m, 10'h200,
               SegE, Seg2);
    end
    press(3'b100);
    total++;
    if (leds_m !== 10'h200) begin
      bad++;
      $display("FAIL lose_holds got=%h exp=%h", leds_m, 10'h200);
    end
  endtask

  task automatic test_restart_double_press();
    do_start(8'h00);
    total++;
    if (leds_m !== 10'd0 || segd0_m !== Seg0 || segd3_m !== SegP) begin
      bad++;
      $display("FAIL restart_add got=%h/%h/%h exp=%h/%h/%h", leds_m, segd0_m, segd3_m, 10'd0, Seg0,
               SegP);
    end
    @(negedge clock);
    total++;
    if (segd0_m !== Seg1 || leds_m !== 10'h004) begin
      bad++;
      $display("FAIL restart_level got=%h/%h exp=%h/%h", segd0_m, leds_m, Seg1, 10'h004);
    end
    capture_show(1'b0, 100);
    press(3'b011);
    total++;
    if (!cap_ok || leds_m !== 10'h200 || segd3_m !== SegE) begin
      bad++;
      $display("FAIL double_press got=ok%0d %h/%h exp=ok1 %h/%h", cap_ok, leds_m, segd3_m, 10'h200,
               SegE);
    end
  endtask

  task automatic test_timeout();
    int still;
    do_start(8'h00);
    capture_show(1'b0, 100);
    still = cap_ok ? 1 : 0;
    for (int i = 0; i < 999; i++) begin
      @(negedge clock);
      if (leds_m[7] && !leds_m[9]) still++;
    end
    total++;
    if (still != 1000) begin
      bad++;
      $display("FAIL timeout_window got=%0d exp=%0d", still, 1000);
    end
    @(negedge clock);
    total++;
    if (leds_m !== 10'h200 || segd3_m !== SegE) begin
      bad++;
      $display("FAIL timeout_lose got=%h/%h exp=%h/%h", leds_m, segd3_m, 10'h200, SegE);
    end
  endtask

  task automatic test_reset_mid_show();
    do_start(8'h3C);
    repeat (3) @(negedge clock);
    total++;
    if (leds_m !== 10'h002) begin
      bad++;
      $display("FAIL seed3c_colour got=%h exp=%h", leds_m, 10'h002);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (leds_m !== 10'd0 || {segd3_m, segd2_m, segd1_m, segd0_m} !== {4{SegBl}}) begin
      bad++;
      $display("FAIL async_reset got=%h %h exp=%h %h", leds_m, {segd3_m, segd2_m, segd1_m, segd0_m},
               10'd0, {4{SegBl}});
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if (leds_m !== 10'd0 || segd3_m !== SegBl || segd0_m !== SegBl) begin
      bad++;
      $display("FAIL resume_idle got=%h/%h/%h exp=%h/%h/%h", leds_m, segd3_m, segd0_m, 10'd0, SegBl,
               SegBl);
    end
  endtask

  task automatic test_win();
    bit ok1;
    do_start(8'h00);
    capture_show(1'b1, 100);
    ok1 = cap_ok;
    press(3'b100);
    capture_show(1'b1, 100);
    total++;
    if (!ok1 || !cap_ok || seen_col.size() != 2 || seen_col[1] !== 3'b010) begin
      bad++;
      $display("FAIL win_rounds got=ok%0d,%0d n%0d exp=ok1,1 n2", ok1, cap_ok, seen_col.size());
    end
    press(3'b100);
    press(3'b010);
    total++;
    if (leds_w !== 10'h100 || {segd3_w, segd2_w, segd1_w, segd0_w} !== {Seg0, SegBl, SegBl, Seg2})
    begin
      bad++;
      $display("FAIL win_state got=%h %h exp=%h %h", leds_w, {segd3_w, segd2_w, segd1_w, segd0_w},
               10'h100, {Seg0, SegBl, SegBl, Seg2});
    end
    press(3'b001);
    press(3'b110);
    total++;
    if (leds_w !== 10'h100 || segd3_w !== Seg0) begin
      bad++;
      $display("FAIL win_holds got=%h/%h exp=%h/%h", leds_w, segd3_w, 10'h100, Seg0);
    end
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_second_round();
    test_wrong_button();
    test_restart_double_press();
    test_timeout();
    test_reset_mid_show();
    test_win();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/genius_game.md
# genius_game

Memory ("Genius"/Simon) game core for the FPGA board top level: plays a growing pseudo-random sequence of three colours on LEDs, then checks the player's button presses against it. The current level appears in decimal on seven-segment digits. A status indication shows on the last digit and on the high LEDs. The block sits directly under the board wrapper, which connects the 50 MHz clock, push-buttons, slide switches, displays and LEDs.

## Interface
Parameters:
- SHOW_CYCLES, 8: clock cycles a sequence colour stays lit.
- GAP_CYCLES, 4: dark cycles after each shown colour.
- TIMEOUT_CYCLES, 1000: idle cycles allowed in the input phase before a loss.
- MAX_LEN, 16: sequence length that wins the game (2..99).

Ports:
- clock, in, 1: single system clock.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: level; a rising edge starts or restarts a game.
- btn, in, 3: player colour buttons; btn[i] is colour i, active-high.
- sw, in, 8 ([9:2]): LFSR seed, sampled on start.
- segd0, out, 7: level units digit.
- segd1, out, 7: level tens digit.
- segd2, out, 7: always blank.
- segd3, out, 7: status digit.
- leds, out, 10: [2:0] colour lamps, [7] input phase, [8] win, [9] lose, [6:3] always 0.

## Operation
- start and btn are registered once. Action is taken on the 0→1 edge of the registered value, so a pulse must span a rising clock edge.
- The LFSR is 8-bit Fibonacci with taps at bits 7, 5, 4, 3.
  - Step: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - On start it loads sw; if sw is 0 it loads 8'hA5.
- New colour: step the LFSR, then take the new lfsr[1:0]; a value of 3 maps to 0. The colour is appended to the sequence memory (MAX_LEN × 2 bits).
- States:
  - IDLE: waits for start.
  - ADD: appends one colour; level <= level+1.
  - SHOW_ON: lights the colour at the current show index.
  - SHOW_OFF: dark gap after each colour.
  - INPUT: waits for the player's presses.
  - WIN and LOSE: terminal states.
- Transitions:
  - start edge from any state: load seed, level=0, index=0, go to ADD.
  - ADD → SHOW_ON with show index 0.
  - SHOW_ON → SHOW_OFF after SHOW_CYCLES.
  - SHOW_OFF → SHOW_ON for the next index after GAP_CYCLES. After the last entry (index = level−1) it goes to INPUT with input index 0 and the timeout counter cleared.
- INPUT rules:
  - A button-edge vector with exactly one bit set equal to the one-hot of seq[idx] is correct: idx++ and the timeout counter is cleared.
  - If that was the last entry and level = MAX_LEN, go to WIN.
  - If that was the last entry and level < MAX_LEN, go to SHOW_OFF (one gap), then ADD.
  - A wrong colour, or more than one simultaneous edge, goes to LOSE.
  - Timeout counter reaching TIMEOUT_CYCLES goes to LOSE.
- WIN and LOSE hold until a start edge or reset.
- Outputs:
  - leds[2:0]: one-hot seq[idx] in SHOW_ON. In INPUT it echoes the registered btn level. Otherwise 0.
  - leds[7] = INPUT; leds[8] = WIN; leds[9] = LOSE.
- Seven-segment encoding is active-low, ordered {g,f,e,d,c,b,a}: blank 7'h7F, "0" 7'b1000000, "E" 7'b0000110, "P" 7'b0001100.
  - segd1/segd0 show level in decimal; segd1 is blank when level < 10.
  - In IDLE, segd0 and segd1 are blank.
  - segd3 shows "P" in ADD/SHOW/INPUT, "E" in LOSE, "0" in WIN, and is blank in IDLE.

## Timing
- Reset is asynchronous: state IDLE, level 0, LFSR 8'hA5, all counters 0, leds = 0, all segd = 7'h7F.
- Reset deasserted mid-game always resumes in IDLE.
- The start edge is detected one cycle after sampling; ADD is entered the following cycle.
- ADD lasts 1 cycle.
- SHOW_ON for colour k begins 1 cycle after ADD, or after the preceding gap.
- Outputs are registered or decoded from registered state, with no combinational path from inputs to outputs.
- A correct final press moves to SHOW_OFF on the next cycle.
- start asserted together with a button edge: start wins.

## Structure
- Shared package `genius_pkg`: state enum, MAX_LEN default, seven-segment constants (blank, E, P, digit table 0–9).
- One sub-module, `seg7_decoder`: 4-bit digit to active-low 7-segment, with a blank input.
- The LFSR and sequence memory stay inline.

## Test plan
- Reset asserted mid-SHOW_ON → leds = 0, segd all 7'h7F immediately; IDLE after release.
- sw=0, start pulse → first colour 2 (LFSR 8'h4A): leds = 3'b100 for exactly 8 cycles, segd0 shows "1", segd3 "P"; then INPUT, leds[7]=1.
- Correct press btn[2] → level 2 appended, colour 1 (LFSR 8'h95); show sequence 2,1 with 4-cycle gaps.
- Wrong button (btn[0] when 2 expected), or btn[1] and btn[0] together → LOSE: leds[9]=1, segd3 "E".
- No press for 1000 cycles in INPUT → LOSE. A new start → ADD with level 1 again.
- MAX_LEN=2, correct inputs through both rounds → WIN: leds[8]=1, segd3 "0", segd0 "2". State holds with further button presses.
